// File: rtl/riscv_v_rf_param_if.sv
// rtl/riscv_v_rf_param_if.sv - write, read, mask and debug bus of the vector register file
interface riscv_v_rf_param_if #(
  parameter int VLEN         = 128,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int NB = VLEN / 8;

  logic [AW-1:0]                wr_addr;
  logic [NB-1:0]                wr_en;
  logic [VLEN-1:0]              data_in;
  logic [NUM_RD_PORTS*AW-1:0]   rd_addr;
  logic [NUM_RD_PORTS*VLEN-1:0] data_out;
  logic [AW-1:0]                mask_merge_addr;
  logic [NB-1:0]                mask;
  logic [NB-1:0]                mask_merge;
  logic [AW-1:0]                syn_addr;
  logic [VLEN-1:0]              syn_data;
  logic                         init_busy;

  modport master (
    output wr_addr, wr_en, data_in, rd_addr, mask_merge_addr, syn_addr,
    input  data_out, mask, mask_merge, syn_data, init_busy
  );

  modport slave (
    input  wr_addr, wr_en, data_in, rd_addr, mask_merge_addr, syn_addr,
    output data_out, mask, mask_merge, syn_data, init_busy
  );
endinterface

// File: rtl/riscv_v_rf_param.sv
// rtl/riscv_v_rf_param.sv - vector register file with self-clear after reset
// Optional write-to-read forwarding is enabled by defining RISCV_V_RF_BYPASS_EN.
module riscv_v_rf_param #(
  parameter int VLEN         = 128,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic               clk,
  input  logic               rst,
  riscv_v_rf_param_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int NB = VLEN / 8;
  localparam int MB = VLEN / 64;

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt, clr_nxt;
  logic [VLEN-1:0] regs [NUM_REGS];
  logic [VLEN-1:0] rd_word;
  logic [MB*8-1:0] mask_word;
  logic [MB*8-1:0] merge_word;
  logic            busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    if (state == CLEAR) begin
      clr_nxt = clr_cnt + 1'b1;
      if (clr_cnt == AW'(NUM_REGS - 1))
        state_nxt = READY;
    end
  end

  assign busy          = (state == CLEAR);
  assign bus.init_busy = busy;

  // Contents are frozen during the reset cycle itself; clearing starts on the next edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_cnt] <= '0;
      end else begin
        for (int b = 0; b < NB; b++)
          if (bus.wr_en[b])
            regs[bus.wr_addr][b*8 +: 8] <= bus.data_in[b*8 +: 8];
      end
    end
  end

  always_comb begin
    bus.data_out   = '0;
    bus.mask       = '0;
    bus.mask_merge = '0;
    bus.syn_data   = '0;
    rd_word        = '0;
    mask_word      = regs[0][MB*8-1:0];
    merge_word     = regs[bus.mask_merge_addr][MB*8-1:0];
`ifdef RISCV_V_RF_BYPASS_EN
    for (int b = 0; b < MB; b++) begin
      if (bus.wr_en[b] && bus.wr_addr == '0)
        mask_word[b*8 +: 8] = bus.data_in[b*8 +: 8];
      if (bus.wr_en[b] && bus.wr_addr == bus.mask_merge_addr)
        merge_word[b*8 +: 8] = bus.data_in[b*8 +: 8];
    end
`endif
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_word = regs[bus.rd_addr[p*AW +: AW]];
`ifdef RISCV_V_RF_BYPASS_EN
      for (int b = 0; b < NB; b++)
        if (bus.wr_en[b] && bus.wr_addr == bus.rd_addr[p*AW +: AW])
          rd_word[b*8 +: 8] = bus.data_in[b*8 +: 8];
`endif
      if (!busy)
        bus.data_out[p*VLEN +: VLEN] = rd_word;
    end
    if (!busy) begin
      bus.mask       = mask_word;
      bus.mask_merge = merge_word;
      bus.syn_data   = regs[bus.syn_addr];
    end
  end
endmodule

// File: tb/tb_riscv_v_rf_param.sv
// tb/tb_riscv_v_rf_param.sv - directed vector bench for riscv_v_rf_param
module tb_riscv_v_rf_param;
  localparam int VLEN = 128;
  localparam int NR   = 32;
  localparam int NP   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   n;

  always #5 clk = ~clk;

  riscv_v_rf_param_if #(.VLEN(VLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) bus ();

  riscv_v_rf_param #(.VLEN(VLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]   addr;
    logic [15:0]  we;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vec [6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.init_busy && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  logic [127:0] exp_w;
  logic [15:0]  exp_m;

  initial begin
    vec[0] = '{5'd0,  16'hFFFF, 128'hA5, 128'hA5};
    vec[1] = '{5'd7,  16'hFFFF, {16{8'hFF}}, {16{8'hFF}}};
    vec[2] = '{5'd7,  16'h0001, 128'hAB, {{15{8'hFF}}, 8'hAB}};
    vec[3] = '{5'd9,  16'h8000, {16{8'hCC}}, {8'hCC, 120'h0}};
    vec[4] = '{5'd31, 16'h00F0, 128'h0123456789ABCDEF_FEDCBA9876543210, 128'h0000000000000000_FEDCBA9800000000};
    vec[5] = '{5'd31, 16'h000F, 128'h11223344, 128'h0000000000000000_FEDCBA9811223344};

    bus.wr_addr = '0;
    bus.wr_en = '0;
    bus.data_in = '0;
    bus.rd_addr = '0;
    bus.mask_merge_addr = '0;
    bus.syn_addr = '0;

    tick();
    chk("reset_busy", 256'(bus.init_busy), 256'd1);
    chk("reset_data_out", 256'(bus.data_out), 256'd0);
    chk("reset_mask", 256'(bus.mask), 256'd0);
    chk("reset_syn", 256'(bus.syn_data), 256'd0);
    rst = 1'b0;

    n = 0;
    while (bus.init_busy && n < 200) begin
      if (n == 3) begin
        bus.wr_addr = 5'd5;
        bus.wr_en = 16'hFFFF;
        bus.data_in = {16{8'h5A}};
        bus.rd_addr = {5'd5, 5'd5};
        #1;
        chk("busy_data_out_forced", 256'(bus.data_out), 256'd0);
      end
      tick();
      bus.wr_en = '0;
      n++;
    end
    chk("clear_cycles", 256'(n), 256'd32);

    for (int r = 0; r < NR; r++) begin
      bus.syn_addr = 5'(r);
      #1;
      chk($sformatf("zero_v%0d", r), 256'(bus.syn_data), 256'd0);
    end

    for (int i = 0; i < 6; i++) begin
      bus.wr_addr = vec[i].addr;
      bus.wr_en = vec[i].we;
      bus.data_in = vec[i].data;
      bus.rd_addr = {vec[i].addr, 5'd1};
      bus.syn_addr = vec[i].addr;
      tick();
      bus.wr_en = '0;
      #1;
      chk($sformatf("vec%0d_syn", i), 256'(bus.syn_data), 256'(vec[i].exp));
      chk($sformatf("vec%0d_port1", i), 256'(bus.data_out[VLEN +: VLEN]), 256'(vec[i].exp));
    end

    bus.mask_merge_addr = 5'd0;
    #1;
    chk("mask_v0", 256'(bus.mask), 256'h00A5);
    chk("mask_merge_v0", 256'(bus.mask_merge), 256'h00A5);
    bus.mask_merge_addr = 5'd7;
    #1;
    chk("mask_merge_v7", 256'(bus.mask_merge), 256'hFFAB);

    bus.wr_addr = 5'd3;
    bus.wr_en = 16'hFFFF;
    bus.data_in = {16{8'hAA}};
    tick();
    bus.wr_en = 16'h000F;
    bus.data_in = {{12{8'h55}}, 32'h12345678};
    bus.rd_addr = {5'd3, 5'd3};
    bus.syn_addr = 5'd3;
    #1;
`ifdef RISCV_V_RF_BYPASS_EN
    exp_w = {{12{8'hAA}}, 32'h12345678};
`else
    exp_w = {16{8'hAA}};
`endif
    chk("same_cycle_port0", 256'(bus.data_out[0 +: VLEN]), 256'(exp_w));
    chk("same_cycle_port1", 256'(bus.data_out[VLEN +: VLEN]), 256'(exp_w));
    chk("same_cycle_syn_old", 256'(bus.syn_data), 256'({16{8'hAA}}));
    tick();
    bus.wr_en = '0;
    #1;
    chk("after_write_v3", 256'(bus.syn_data), 256'({{12{8'hAA}}, 32'h12345678}));

    bus.wr_addr = 5'd0;
    bus.wr_en = 16'h0005;
    bus.data_in = 128'h00EE003C;
    bus.mask_merge_addr = 5'd0;
    bus.syn_addr = 5'd0;
    #1;
`ifdef RISCV_V_RF_BYPASS_EN
    exp_m = 16'h003C;
`else
    exp_m = 16'h00A5;
`endif
    chk("mask_same_cycle", 256'(bus.mask), 256'(exp_m));
    chk("mask_merge_same_cycle", 256'(bus.mask_merge), 256'(exp_m));
    chk("syn_v0_not_bypassed", 256'(bus.syn_data), 256'h00A5);
    tick();
    bus.wr_en = '0;
    #1;
    chk("mask_after", 256'(bus.mask), 256'h003C);
    chk("v0_after", 256'(bus.syn_data), 256'h00EE003C);

    rst = 1'b1;
    bus.rd_addr = {5'd7, 5'd7};
    tick();
    rst = 1'b0;
    #1;
    chk("rerst_busy", 256'(bus.init_busy), 256'd1);
    chk("rerst_mask_forced", 256'(bus.mask), 256'd0);
    chk("rerst_data_out_forced", 256'(bus.data_out), 256'd0);
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(n);
    chk("midclear_cycles", 256'(n), 256'd32);
    bus.syn_addr = 5'd7;
    #1;
    chk("midclear_v7_zero", 256'(bus.syn_data), 256'd0);
    chk("midclear_port0_v7", 256'(bus.data_out[0 +: VLEN]), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
